// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS instruction decoder: widths, opcode/funct
// encodings, ALU operation codes and immediate-extension modes.
package mips_pkg;

    localparam int unsigned D_WIDTH  = 32;
    localparam int unsigned RA_WIDTH = 5;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_ANDI  = 6'd12;
    localparam logic [5:0] OP_ORI   = 6'd13;
    localparam logic [5:0] OP_LUI   = 6'd15;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam logic [5:0] FN_SLL = 6'd0;
    localparam logic [5:0] FN_SRL = 6'd2;
    localparam logic [5:0] FN_MUL = 6'd24;
    localparam logic [5:0] FN_DIV = 6'd26;
    localparam logic [5:0] FN_ADD = 6'd32;
    localparam logic [5:0] FN_SUB = 6'd34;

    localparam logic [RA_WIDTH-1:0] RA_LINK = 5'd31;

    typedef enum logic [3:0] {
        ALU_NOP, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR,
        ALU_SLL, ALU_SRL, ALU_MUL, ALU_DIV, ALU_LUI
    } alu_op_e;

    typedef enum logic [2:0] {
        ImmNone, ImmSign, ImmZero, ImmUpper, ImmJump
    } imm_mode_e;

endpackage

// File: rtl/mips_imm_ext.sv
// Combinational immediate extender: 16-bit sign/zero/upper or 26-bit jump target.
module mips_imm_ext
    import mips_pkg::*;
(
    input  logic [25:0]        imm_i,
    input  imm_mode_e          mode_i,
    output logic [D_WIDTH-1:0] imm_ext_o
);

    always_comb begin
        imm_ext_o = '0;
        case (mode_i)
            ImmSign:  imm_ext_o = {{16{imm_i[15]}}, imm_i[15:0]};
            ImmZero:  imm_ext_o = {16'h0, imm_i[15:0]};
            ImmUpper: imm_ext_o = {imm_i[15:0], 16'h0};
            ImmJump:  imm_ext_o = {6'b0, imm_i};
            default:  imm_ext_o = '0;
        endcase
    end

endmodule

// File: rtl/mips_instr_decoder.sv
// MIPS instruction decoder: combinational field slices plus registered control decode.
// Define MIPS_DEC_ILLEGAL_EN to drive illegal and the sticky illegal_seen flag.
module mips_instr_decoder
    import mips_pkg::*;
(
    input  logic                Clk,
    input  logic                Rst,
    input  logic [D_WIDTH-1:0]  IR,
    input  logic                ir_valid,
    output logic [5:0]          op,
    output logic [RA_WIDTH-1:0] rs,
    output logic [RA_WIDTH-1:0] rt,
    output logic [RA_WIDTH-1:0] rd,
    output logic [4:0]          sh,
    output logic [5:0]          fn,
    output logic                dec_valid,
    output alu_op_e             alu_op,
    output logic                itype,
    output logic                jtype,
    output logic [D_WIDTH-1:0]  imm_ext,
    output logic                wr_en,
    output logic [RA_WIDTH-1:0] wr_addr,
    output logic                illegal,
    output logic                illegal_seen
);

    assign op = IR[31:26];
    assign rs = IR[25:21];
    assign rt = IR[20:16];
    assign rd = IR[15:11];
    assign sh = IR[10:6];
    assign fn = IR[5:0];

    alu_op_e             alu_d;
    imm_mode_e           mode_d;
    logic                itype_d, jtype_d, wr_en_d, ill_d;
    logic [RA_WIDTH-1:0] wa_d;
    logic [D_WIDTH-1:0]  imm_d;

    always_comb begin
        alu_d   = ALU_NOP;
        mode_d  = ImmNone;
        itype_d = 1'b0;
        jtype_d = 1'b0;
        wr_en_d = 1'b0;
        wa_d    = '0;
        ill_d   = 1'b0;
        case (op)
            OP_RTYPE: begin
                wr_en_d = 1'b1;
                wa_d    = rd;
                case (fn)
                    FN_SLL:  alu_d = ALU_SLL;
                    FN_SRL:  alu_d = ALU_SRL;
                    FN_MUL:  alu_d = ALU_MUL;
                    FN_DIV:  alu_d = ALU_DIV;
                    FN_ADD:  alu_d = ALU_ADD;
                    FN_SUB:  alu_d = ALU_SUB;
                    default: ill_d = 1'b1;
                endcase
            end
            OP_ADDI, OP_LW: begin
                itype_d = 1'b1; wa_d = rt; alu_d = ALU_ADD; mode_d = ImmSign; wr_en_d = 1'b1;
            end
            OP_ANDI: begin
                itype_d = 1'b1; wa_d = rt; alu_d = ALU_AND; mode_d = ImmZero; wr_en_d = 1'b1;
            end
            OP_ORI: begin
                itype_d = 1'b1; wa_d = rt; alu_d = ALU_OR; mode_d = ImmZero; wr_en_d = 1'b1;
            end
            OP_LUI: begin
                itype_d = 1'b1; wa_d = rt; alu_d = ALU_LUI; mode_d = ImmUpper; wr_en_d = 1'b1;
            end
            OP_SW: begin
                itype_d = 1'b1; wa_d = rt; alu_d = ALU_ADD; mode_d = ImmSign;
            end
            OP_BEQ, OP_BNE: begin
                itype_d = 1'b1; wa_d = rt; alu_d = ALU_SUB; mode_d = ImmSign;
            end
            OP_J: begin
                jtype_d = 1'b1; mode_d = ImmJump;
            end
            OP_JAL: begin
                jtype_d = 1'b1; mode_d = ImmJump; wr_en_d = 1'b1; wa_d = RA_LINK;
            end
            default: ill_d = 1'b1;
        endcase
        // Unsupported encodings collapse to a harmless NOP with no side effects.
        if (ill_d) begin
            alu_d   = ALU_NOP;
            mode_d  = ImmNone;
            itype_d = 1'b0;
            jtype_d = 1'b0;
            wr_en_d = 1'b0;
            wa_d    = '0;
        end
        if (wa_d == '0) begin
            wr_en_d = 1'b0;
        end
    end

    mips_imm_ext u_imm_ext (
        .imm_i     (IR[25:0]),
        .mode_i    (mode_d),
        .imm_ext_o (imm_d)
    );

    logic                dec_valid_q, itype_q, jtype_q, wr_en_q;
    alu_op_e             alu_q;
    logic [D_WIDTH-1:0]  imm_q;
    logic [RA_WIDTH-1:0] wa_q;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            dec_valid_q <= 1'b0;
            alu_q       <= ALU_NOP;
            itype_q     <= 1'b0;
            jtype_q     <= 1'b0;
            imm_q       <= '0;
            wr_en_q     <= 1'b0;
            wa_q        <= '0;
        end else begin
            dec_valid_q <= ir_valid;
            if (ir_valid) begin
                alu_q   <= alu_d;
                itype_q <= itype_d;
                jtype_q <= jtype_d;
                imm_q   <= imm_d;
                wr_en_q <= wr_en_d;
                wa_q    <= wa_d;
            end
        end
    end

    assign dec_valid = dec_valid_q;
    assign alu_op    = alu_q;
    assign itype     = itype_q;
    assign jtype     = jtype_q;
    assign imm_ext   = imm_q;
    assign wr_en     = wr_en_q;
    assign wr_addr   = wa_q;

`ifdef MIPS_DEC_ILLEGAL_EN
    logic illegal_q, illegal_seen_q;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            illegal_q      <= 1'b0;
            illegal_seen_q <= 1'b0;
        end else if (ir_valid) begin
            illegal_q <= ill_d;
            if (ill_d) begin
                illegal_seen_q <= 1'b1;
            end
        end
    end

    assign illegal      = illegal_q;
    assign illegal_seen = illegal_seen_q;
`else
    assign illegal      = 1'b0;
    assign illegal_seen = 1'b0;
`endif

endmodule

// File: tb/tb_mips_instr_decoder.sv
// Directed scoreboard bench for mips_instr_decoder; honours MIPS_DEC_ILLEGAL_EN.
module tb_mips_instr_decoder;
    import mips_pkg::*;

`ifdef MIPS_DEC_ILLEGAL_EN
    localparam bit ILL = 1'b1;
`else
    localparam bit ILL = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Rst;
    logic [31:0] IR;
    logic        ir_valid;
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd, sh, wr_addr;
    logic        dec_valid, itype, jtype, wr_en, illegal, illegal_seen;
    alu_op_e     alu_op;
    logic [31:0] imm_ext;

    int checks = 0;
    int failures = 0;

    always #5 Clk = ~Clk;

    mips_instr_decoder dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .IR           (IR),
        .ir_valid     (ir_valid),
        .op           (op),
        .rs           (rs),
        .rt           (rt),
        .rd           (rd),
        .sh           (sh),
        .fn           (fn),
        .dec_valid    (dec_valid),
        .alu_op       (alu_op),
        .itype        (itype),
        .jtype        (jtype),
        .imm_ext      (imm_ext),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .illegal      (illegal),
        .illegal_seen (illegal_seen)
    );

    typedef struct {
        bit          dv;
        logic [3:0]  alu;
        bit          it;
        bit          jt;
        logic [31:0] imm;
        bit          we;
        logic [4:0]  wa;
        bit          ill;
        bit          seen;
        bit          chk_imm;
        bit          chk_wa;
    } exp_t;

    exp_t sb[$];
    exp_t last;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    function automatic exp_t ex(logic [3:0] alu, bit it, bit jt, logic [31:0] imm, bit we,
                                logic [4:0] wa, bit ill, bit seen);
        exp_t e;
        e.dv = 1'b1; e.alu = alu; e.it = it; e.jt = jt; e.imm = imm; e.we = we; e.wa = wa;
        e.ill = ill; e.seen = seen; e.chk_imm = 1'b1; e.chk_wa = 1'b1;
        return e;
    endfunction

    // Drive one cycle, check the combinational slices, then score the registered decode.
    task automatic step(input logic rst, input logic v, input logic [31:0] ir, input exp_t e);
        exp_t got;
        sb.push_back(e);
        last = e;
        Rst = rst; ir_valid = v; IR = ir;
        #1;
        chk("op", op, ir[31:26]);
        chk("rs", rs, ir[25:21]);
        chk("rt", rt, ir[20:16]);
        chk("rd", rd, ir[15:11]);
        chk("sh", sh, ir[10:6]);
        chk("fn", fn, ir[5:0]);
        @(posedge Clk);
        #1;
        got = sb.pop_front();
        chk("dec_valid", dec_valid, got.dv);
        chk("alu_op", alu_op, got.alu);
        chk("itype", itype, got.it);
        chk("jtype", jtype, got.jt);
        if (got.chk_imm) chk("imm_ext", imm_ext, got.imm);
        chk("wr_en", wr_en, got.we);
        if (got.chk_wa) chk("wr_addr", wr_addr, got.wa);
        chk("illegal", illegal, got.ill);
        chk("illegal_seen", illegal_seen, got.seen);
    endtask

    initial begin
        exp_t z, h, e;
        z = ex(ALU_NOP, 0, 0, 32'h0, 0, 5'd0, 0, 0);
        z.dv = 1'b0;

        Rst = 1'b1; ir_valid = 1'b0; IR = 32'h2128_0005;
        #1;
        chk("slice_op", op, 32'd8);
        chk("slice_rs", rs, 32'd9);
        chk("slice_rt", rt, 32'd8);
        chk("slice_rd", rd, 32'd0);
        chk("slice_sh", sh, 32'd0);
        chk("slice_fn", fn, 32'd5);
        @(posedge Clk); #1;
        @(posedge Clk); #1;

        step(1, 1, 32'h2008_FFFF, z);                                   // reset beats ir_valid
        step(0, 1, 32'h2008_FFFF, ex(ALU_ADD, 1, 0, 32'hFFFF_FFFF, 1, 5'd8, 0, 0));
        step(0, 1, 32'h012A_4020, ex(ALU_ADD, 0, 0, 32'h0, 1, 5'd8, 0, 0));
        step(0, 1, 32'h0009_4102, ex(ALU_SRL, 0, 0, 32'h0, 1, 5'd8, 0, 0));
        step(0, 1, 32'h3508_8000, ex(ALU_OR, 1, 0, 32'h0000_8000, 1, 5'd8, 0, 0));
        step(0, 1, 32'h3C08_1234, ex(ALU_LUI, 1, 0, 32'h1234_0000, 1, 5'd8, 0, 0));
        step(0, 1, 32'hAC08_0004, ex(ALU_ADD, 1, 0, 32'h0000_0004, 0, 5'd8, 0, 0));
        step(0, 1, 32'h1109_FFFE, ex(ALU_SUB, 1, 0, 32'hFFFF_FFFE, 0, 5'd9, 0, 0));
        step(0, 1, 32'h3108_F0F0, ex(ALU_AND, 1, 0, 32'h0000_F0F0, 1, 5'd8, 0, 0));
        step(0, 1, 32'h0C00_0010, ex(ALU_NOP, 0, 1, 32'h0000_0010, 1, 5'd31, 0, 0));
        e = ex(ALU_NOP, 0, 1, 32'h0000_0100, 0, 5'd0, 0, 0);
        e.chk_wa = 1'b0;
        step(0, 1, 32'h0800_0100, e);
        step(0, 1, 32'h0000_0020, ex(ALU_ADD, 0, 0, 32'h0, 0, 5'd0, 0, 0));  // rd=$0

        e = ex(ALU_NOP, 0, 0, 32'h0, 0, 5'd0, ILL, ILL);
        e.chk_imm = 1'b0; e.chk_wa = 1'b0;
        step(0, 1, 32'hFC00_0000, e);
        step(0, 1, 32'h0000_0001, e);
        h = last; h.dv = 1'b0;
        step(0, 0, 32'h2008_FFFF, h);                                   // hold with ir_valid=0
        step(0, 1, 32'h2009_0001, ex(ALU_ADD, 1, 0, 32'h0000_0001, 1, 5'd9, 0, ILL));
        h = last; h.dv = 1'b0;
        step(0, 0, 32'h0000_0000, h);
        step(1, 1, 32'h0000_0001, z);
        step(0, 1, 32'h2000_0005, ex(ALU_ADD, 1, 0, 32'h0000_0005, 0, 5'd0, 0, 0));

        checks++;
        assert (sb.size() == 0) else begin
            failures++;
            $display("FAIL scoreboard_empty observed=%0d expected=0", sb.size());
            $error("check scoreboard_empty");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mips_instr_decoder.md
Name: mips_instr_decoder

Overview:
- Decodes a 32-bit MIPS instruction word for the GPP controller.
- Field outputs op/rs/rt/rd/sh/fn are pure combinational slices. The GPP execute state reads them in the same cycle that IR is stable.
- Also produces registered control signals: instruction class, ALU operation, immediate extension, register-write target and illegal flag. These are qualified by a valid strobe, with one-cycle latency.

Parameters:
- D_WIDTH, 32, instruction/data width; only 32 is supported.
- RA_WIDTH, 5, register address width.

Ports:
- Clk input 1: clock, rising edge.
- Rst input 1: reset, synchronous, active-high.
- IR input 32: instruction word.
- ir_valid input 1: IR holds a new instruction to decode this cycle.
- op output 6: IR[31:26], combinational.
- rs output 5: IR[25:21], combinational.
- rt output 5: IR[20:16], combinational.
- rd output 5: IR[15:11], combinational.
- sh output 5: IR[10:6], combinational.
- fn output 6: IR[5:0], combinational.
- dec_valid output 1: registered control outputs are valid.
- alu_op output 4: ALU operation code (package enum).
- itype output 1: I-type instruction.
- jtype output 1: J-type instruction.
- imm_ext output 32: extended immediate, registered.
- wr_en output 1: instruction writes a register.
- wr_addr output 5: destination register.
- illegal output 1: unsupported encoding.

Behaviour:
- Clocking: one clock Clk; reset Rst is synchronous and active-high. All registered outputs reset to 0, including dec_valid, alu_op=ALU_NOP, imm_ext, wr_en, wr_addr and illegal.
- Field slices: track IR with zero latency and are unaffected by Rst.
- Registered outputs: on each rising edge with ir_valid=1, they capture the decode of IR. dec_valid=1 for exactly that following cycle.
- ir_valid=0: dec_valid goes 0 and the other registered outputs hold their values.
- Back-to-back ir_valid: each cycle produces a new decode; no stall and no handshake.
- R-type (op=0), itype=0, jtype=0, wr_addr=rd, wr_en=1, imm_ext=0:
  - fn 0: SLL
  - fn 2: SRL
  - fn 24: MUL
  - fn 26: DIV
  - fn 32: ADD
  - fn 34: SUB
  - any other fn: illegal.
- I-type, itype=1, wr_addr=rt:
  - op 8 ADDI: ADD, sign-extend, wr_en=1.
  - op 12 ANDI: AND, zero-extend, wr_en=1.
  - op 13 ORI: OR, zero-extend, wr_en=1.
  - op 15 LUI: LUI, imm_ext={imm,16'h0}, wr_en=1.
  - op 35 LW: ADD, sign-extend, wr_en=1.
  - op 43 SW: ADD, sign-extend, wr_en=0.
  - op 4 BEQ: SUB, sign-extend, wr_en=0.
  - op 5 BNE: SUB, sign-extend, wr_en=0.
- J-type, jtype=1, alu_op=NOP:
  - op 2 J: wr_en=0.
  - op 3 JAL: wr_en=1, wr_addr=31.
  - imm_ext={6'b0, IR[25:0]}.
- Writes to $0: wr_addr=0 forces wr_en=0.
- Illegal: any other op, or an unlisted R-type fn, gives illegal=1, alu_op=NOP, wr_en=0, itype=jtype=0.
- Reset and ir_valid together: reset wins, dec_valid=0.

Optional Feature:
- Macro: MIPS_DEC_ILLEGAL_EN.
- Defined: the illegal output is driven as above, and a sticky register illegal_seen (extra output, 1 bit) sets on any illegal decode and clears only on Rst.
- Undefined: illegal and illegal_seen are tied to 0. Unsupported encodings still decode as NOP with wr_en=0.

Decomposition:
- Package mips_pkg holds the opcode constants (OP_RTYPE, OP_ADDI, ...), funct constants (FN_SLL, ...), the alu_op enum (ALU_NOP, ADD, SUB, AND, OR, SLL, SRL, MUL, DIV, LUI), and widths D_WIDTH/RA_WIDTH.
- One sub-module, mips_imm_ext, is natural: a combinational 16/26-bit immediate extender selected by mode sign, zero, upper or jump.

Test Plan:
- Field slicing: IR=32'h2128_0005 → op=8, rs=9, rt=8, rd=0, sh=0, fn=5 in the same cycle.
- ADDI negative immediate: IR=32'h2008_FFFF with ir_valid → next cycle dec_valid=1, alu_op=ADD, itype=1, imm_ext=32'hFFFF_FFFF, wr_en=1, wr_addr=8.
- R-type: IR=32'h012A_4020 (add $8,$9,$10) → alu_op=ADD, wr_addr=8. Then fn=2, sh=4 (32'h0009_4102) → alu_op=SRL, wr_addr=8.
- ORI zero-extension: IR=32'h3508_8000 → imm_ext=32'h0000_8000. JAL 32'h0C00_0010 → jtype=1, wr_addr=31, imm_ext=32'h10.
- Illegal: op=63, then R-type fn=1 → illegal=1, wr_en=0. With MIPS_DEC_ILLEGAL_EN defined, illegal_seen stays 1 until Rst.
- Reset: Rst asserted together with ir_valid → next cycle all registered outputs 0. ADDI with rt=0 → wr_en=0.
